// File: rtl/regfile_param.sv
// regfile_param: two-read/one-write register file with busy tracking,
// optional write-to-read forwarding and a one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_markBusy,
  input  logic [ADDR_WIDTH-1:0] ctrl_markReg,
  output logic                  busy_readA,
  output logic                  busy_readB,
  input  logic                  ctrl_clear,
  output logic                  clear_active
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic wr_ok, mk_ok, mk_wr, fwd_a, fwd_b;
  always_comb begin
    wr_ok = ctrl_writeEnable && state_q == IDLE && ctrl_writeReg != '0;
    mk_ok = ctrl_markBusy && state_q == IDLE && ctrl_markReg != '0;
    mk_wr = mk_ok && ctrl_markReg == ctrl_writeReg;
    fwd_a = BYPASS && wr_ok && ctrl_writeReg == ctrl_readRegA;
    fwd_b = BYPASS && wr_ok && ctrl_writeReg == ctrl_readRegB;
    data_readRegA = fwd_a ? data_writeReg : mem_q[ctrl_readRegA];
    data_readRegB = fwd_b ? data_writeReg : mem_q[ctrl_readRegB];
    busy_readA = fwd_a && !mk_wr ? 1'b0 : busy_q[ctrl_readRegA];
    busy_readB = fwd_b && !mk_wr ? 1'b0 : busy_q[ctrl_readRegB];
    clear_active = state_q == SWEEP;
  end
  // Register 0 is never written or marked, so reset alone keeps it at zero.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[cnt_q] <= '0;
      busy_q[cnt_q] <= 1'b0;
      if (cnt_q == '1) state_q <= IDLE;
      else cnt_q <= cnt_q + 1'b1;
    end else begin
      if (wr_ok) begin
        mem_q[ctrl_writeReg] <= data_writeReg;
        busy_q[ctrl_writeReg] <= 1'b0;
      end
      if (mk_ok) busy_q[ctrl_markReg] <= 1'b1;
      if (ctrl_clear) begin
        state_q <= SWEEP;
        cnt_q <= ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: checks forwarding, no-forwarding and narrow configurations
// of regfile_param against an array-based reference model.
module tb_regfile_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, we, mb, clr;
  logic [4:0] wr, ra, rb, mr;
  logic [31:0] wd;
  logic [31:0] a0, b0, a1, b1;
  logic [15:0] a2, b2;
  logic ba0, bb0, ba1, bb1, ba2, bb2, ca0, ca1, ca2;
  int checks = 0, failures = 0;
  regfile_param u0 (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a0), .data_readRegB(b0), .ctrl_markBusy(mb), .ctrl_markReg(mr),
    .busy_readA(ba0), .busy_readB(bb0), .ctrl_clear(clr), .clear_active(ca0));
  regfile_param #(.BYPASS(1'b0)) u1 (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a1), .data_readRegB(b1), .ctrl_markBusy(mb), .ctrl_markReg(mr),
    .busy_readA(ba1), .busy_readB(bb1), .ctrl_clear(clr), .clear_active(ca1));
  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u2 (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr[2:0]),
    .data_writeReg(wd[15:0]), .ctrl_readRegA(ra[2:0]), .ctrl_readRegB(rb[2:0]),
    .data_readRegA(a2), .data_readRegB(b2), .ctrl_markBusy(mb), .ctrl_markReg(mr[2:0]),
    .busy_readA(ba2), .busy_readB(bb2), .ctrl_clear(clr), .clear_active(ca2));

  // Reference state: [0] models the 32x32 instances, [1] the 8x16 instance.
  logic [31:0] m [2][32];
  bit bz [2][32];
  bit swp [2];
  int idx [2];
  int dep [2] = '{32, 8};

  function automatic int ad(int i, logic [4:0] a);
    return (i == 1) ? int'(a[2:0]) : int'(a);
  endfunction
  function automatic logic [31:0] dm(int i, logic [31:0] d);
    return (i == 1) ? {16'h0, d[15:0]} : d;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int w = ad(i, wr), a = ad(i, ra), b = ad(i, rb), k = ad(i, mr);
      logic [31:0] d = dm(i, wd);
      bit acc = we && !swp[i] && w != 0;
      bit mw = mb && k == w;
      logic [31:0] ea = (acc && w == a) ? d : m[i][a];
      logic [31:0] eb = (acc && w == b) ? d : m[i][b];
      bit eba = (acc && w == a && !mw) ? 1'b0 : bz[i][a];
      bit ebb = (acc && w == b && !mw) ? 1'b0 : bz[i][b];
      if (i == 0) begin
        chk("A_byp", a0, ea);
        chk("B_byp", b0, eb);
        chk("A_nobyp", a1, m[0][a]);
        chk("B_nobyp", b1, m[0][b]);
        chk("busyA_byp", ba0, eba);
        chk("busyB_byp", bb0, ebb);
        chk("busyA_nobyp", ba1, bz[0][a]);
        chk("busyB_nobyp", bb1, bz[0][b]);
        chk("clear_active", ca0, swp[0]);
        chk("clear_active_nobyp", ca1, swp[0]);
      end else begin
        chk("A_small", {16'h0, a2}, ea);
        chk("B_small", {16'h0, b2}, eb);
        chk("busyA_small", ba2, eba);
        chk("busyB_small", bb2, ebb);
        chk("clear_active_small", ca2, swp[1]);
      end
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int w = ad(i, wr), k = ad(i, mr);
      if (rst) begin
        for (int j = 0; j < 32; j++) begin
          m[i][j] = '0;
          bz[i][j] = 1'b0;
        end
        swp[i] = 1'b0;
      end else if (swp[i]) begin
        m[i][idx[i]] = '0;
        bz[i][idx[i]] = 1'b0;
        if (idx[i] == dep[i] - 1) swp[i] = 1'b0;
        else idx[i]++;
      end else begin
        if (we && w != 0) begin
          m[i][w] = dm(i, wd);
          bz[i][w] = 1'b0;
        end
        if (mb && k != 0) bz[i][k] = 1'b1;
        if (clr) begin
          swp[i] = 1'b1;
          idx[i] = 1;
        end
      end
    end
  endtask

  task automatic cyc(bit do_check);
    @(negedge clk);
    if (do_check) check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; mb = 0; clr = 0;
    wr = 0; wd = 0; ra = 0; rb = 0; mr = 0;
  endtask

  task automatic wreg(logic [4:0] r, logic [31:0] d);
    we = 1; wr = r; wd = d;
  endtask

  initial begin
    int n0, n2;
    idle();
    rst = 1;
    cyc(0);
    idle();
    for (int a = 0; a < 32; a += 5) begin
      ra = 5'(a); rb = 5'(31 - a);
      cyc(1);
    end
    wreg(5, 32'hDEADBEEF);
    cyc(1);
    idle(); ra = 5; rb = 5;
    #1;
    chk("r5_A", a0, 32'hDEADBEEF);
    chk("r5_B", b1, 32'hDEADBEEF);
    cyc(1);
    wreg(0, 32'h1234);
    cyc(1);
    idle();
    #1;
    chk("r0_A", a0, 32'h0);
    cyc(1);
    wreg(7, 32'h1);
    cyc(1);
    wreg(7, 32'hA5A5A5A5); ra = 7;
    #1;
    chk("fwd_byp", a0, 32'hA5A5A5A5);
    chk("fwd_nobyp", a1, 32'h1);
    cyc(1);
    idle(); ra = 7;
    #1;
    chk("after_nobyp", a1, 32'hA5A5A5A5);
    cyc(1);
    mb = 1; mr = 9; rb = 9;
    cyc(1);
    idle(); rb = 9;
    #1;
    chk("busy_set", bb0, 1'b1);
    cyc(1);
    wreg(9, 32'h55); rb = 9;
    cyc(1);
    idle(); rb = 9;
    #1;
    chk("busy_cleared", bb0, 1'b0);
    cyc(1);
    wreg(9, 32'h77); mb = 1; mr = 9; rb = 9;
    cyc(1);
    idle(); rb = 9;
    #1;
    chk("mark_wins_busy", bb1, 1'b1);
    chk("mark_wins_data", b0, 32'h77);
    cyc(1);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 39) == 0);
      we = 1'($urandom_range(0, 1));
      mb = ($urandom_range(0, 3) == 0);
      wr = 5'($urandom); mr = 5'($urandom); ra = 5'($urandom); rb = 5'($urandom);
      wd = $urandom;
      cyc(1);
    end
    idle();
    for (int k = 0; k < 40; k++) cyc(1);
    for (int k = 1; k < 32; k++) begin
      wreg(5'(k), $urandom | 32'h1);
      cyc(1);
    end
    idle(); clr = 1;
    cyc(1);
    n0 = 0; n2 = 0;
    for (int j = 0; j < 35; j++) begin
      n0 += int'(ca0); n2 += int'(ca2);
      idle();
      ra = 5'(j); rb = 5'(j + 1);
      if (j < 20) wreg(3, 32'hFFFF_FFFF);
      cyc(1);
    end
    chk("sweep_len", 32'(n0), 32'd31);
    chk("sweep_len_small", 32'(n2), 32'd7);
    idle();
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a);
      #1;
      chk("swept_zero", a0, 32'h0);
      cyc(1);
    end
    for (int k = 1; k < 32; k += 3) begin
      wreg(5'(k), 32'hC0DE_0000 | k); mb = 1; mr = 5'(k + 1);
      cyc(1);
    end
    idle(); clr = 1;
    cyc(1);
    idle();
    for (int j = 1; j < 10; j++) cyc(1);
    rst = 1;
    cyc(1);
    idle();
    chk("reset_mid_sweep", ca0, 1'b0);
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(a);
      #1;
      chk("reset_read", a0, 32'h0);
      chk("reset_busy", bb0, 1'b0);
      cyc(1);
    end
    clr = 1;
    cyc(1);
    idle();
    chk("clear_again", ca0, 1'b1);
    for (int j = 0; j < 33; j++) cyc(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Parameters
REQ-001 DATA_WIDTH, default 32: width in bits of every register and data port.
REQ-002 ADDR_WIDTH, default 5: register address width; DEPTH = 2^ADDR_WIDTH registers.
REQ-003 BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.

Interface
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 ctrl_reset  in  1  reset, synchronous and active-high.
REQ-006 ctrl_writeEnable  in  1  write strobe.
REQ-007 ctrl_writeReg  in  ADDR_WIDTH  write address.
REQ-008 data_writeReg  in  DATA_WIDTH  write data.
REQ-009 ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH each  read addresses, ports A and B.
REQ-010 data_readRegA, data_readRegB  out  DATA_WIDTH each  read data, ports A and B.
REQ-011 ctrl_markBusy  in  1  marks a register as having a pending write.
REQ-012 ctrl_markReg  in  ADDR_WIDTH  address the mark applies to.
REQ-013 busy_readA, busy_readB  out  1 each  busy bit of the register addressed by port A / port B.
REQ-014 ctrl_clear  in  1  starts a sweep that zeroes every register.
REQ-015 clear_active  out  1  high while a sweep is in progress.

Function
REQ-016 Register 0 SHALL always read 0 and never be busy; writes to it and marks on it SHALL have no effect.
REQ-017 Reads SHALL be combinational (zero latency) from stored state on both ports, and simultaneous reads of the same address SHALL be allowed.
REQ-018 A write SHALL update register ctrl_writeReg at the edge where ctrl_writeEnable=1, subject to REQ-016 and REQ-025.
REQ-019 Forwarding with BYPASS=1: if ctrl_writeEnable=1, clear_active=0, ctrl_writeReg!=0 and ctrl_writeReg equals a read address, that port SHALL output data_writeReg in the same cycle; with BYPASS=0 the port SHALL output the stored value.
REQ-020 Busy set/clear: a register's busy bit SHALL be set at the edge where ctrl_markBusy=1 addresses it, and cleared at the edge where a write to it is accepted.
REQ-021 Same register marked and written in the same cycle: the data SHALL be stored and the busy bit SHALL end set (mark wins).
REQ-022 busy_readA and busy_readB SHALL be combinational from the stored busy bits; with BYPASS=1, a same-cycle accepted write to the addressed register SHALL force the output to 0 unless REQ-021 applies.
REQ-023 FSM states: IDLE and SWEEP, plus a sweep counter of ADDR_WIDTH bits.
REQ-024 Sweep timing: ctrl_clear=1 sampled in IDLE at edge N SHALL enter SWEEP with the counter at 1; edge N+k SHALL zero register k and its busy bit; the edge that clears register DEPTH-1 SHALL return to IDLE; clear_active SHALL be high for exactly DEPTH-1 cycles.
REQ-025 In SWEEP, external writes, marks and ctrl_clear SHALL be ignored, forwarding SHALL be off, and reads SHALL return stored values, including registers already cleared.
REQ-026 The counter SHALL not wrap, and a sweep SHALL never revisit register 0.

Reset
REQ-027 When ctrl_reset=1 at an edge: all registers and busy bits SHALL go to 0, the FSM to IDLE, the counter to 0 and clear_active to 0, overriding every other input, including mid-sweep.
REQ-028 Outputs after reset: data_readRegA/B = 0 and busy_readA/B = 0 for any address.

Verification
REQ-029 Write 0xDEADBEEF to r5, then read A=5 and B=5 -> both 0xDEADBEEF; write 0x1234 to r0, read A=0 -> 0.
REQ-030 BYPASS=1: r7 holds 0x1; in one cycle write 0xA5A5A5A5 to r7 and read A=7 -> A=0xA5A5A5A5 that cycle; BYPASS=0 -> A=0x1 that cycle and 0xA5A5A5A5 the next.
REQ-031 Mark r9 -> busy_readB=1 with B=9; write r9 -> busy 0 next cycle; mark and write r9 in the same cycle -> data stored and busy stays 1.
REQ-032 Fill r1..r31 with nonzero values, pulse ctrl_clear -> clear_active high for 31 cycles, rK=0 after edge N+K, a write to r3 during the sweep is ignored, and all registers are 0 afterwards.
REQ-033 Assert ctrl_reset at sweep cycle 10 -> next cycle clear_active=0, all reads 0, all busy 0, and a new ctrl_clear is accepted.
REQ-034 DATA_WIDTH=16, ADDR_WIDTH=3: write 0xFFFF to r7 -> reads 0xFFFF, and a sweep lasts 7 cycles.
